lsu_wb_gather_buffer: RTL and testbench

LSU_WB_GATHER_BUFFER -- requirements
Module: lsu_wb_gather_buffer

---
 rtl/lsu_wb_gather_buffer_pkg.sv | 15 +
 rtl/lsu_word_shift_reg.sv | 38 +++
 rtl/lsu_wb_gather_buffer.sv | 125 ++++++++++++
 tb/tb_lsu_wb_gather_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_wb_gather_buffer_pkg.sv
// Shared LSU definitions: default geometry and the gather/drain FSM encoding.
package lsu_wb_gather_buffer_pkg;

  localparam int unsigned LSU_WORD_W = 32;
  localparam int unsigned LSU_LANES  = 64;
  localparam int unsigned LSU_TAG_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GATHER = 2'd1,
    ST_DONE   = 2'd2,
    ST_DRAIN  = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_word_shift_reg.sv
// Vector register of LANES words: parallel load, or shift down one word with a new top word.
module lsu_word_shift_reg #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned LANES  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load_i,
  input  logic [LANES*WORD_W-1:0]   load_data_i,
  input  logic                      shift_i,
  input  logic [WORD_W-1:0]         top_word_i,
  output logic [LANES*WORD_W-1:0]   q_o
);

  localparam int unsigned VEC_W = LANES * WORD_W;

  logic [VEC_W-1:0] buf_q, buf_d;

  always_comb begin
    buf_d = buf_q;
    if (load_i) begin
      buf_d = load_data_i;
    end else if (shift_i) begin
      buf_d = {top_word_i, buf_q[VEC_W-1:WORD_W]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

  assign q_o = buf_q;

endmodule

// File: rtl/lsu_wb_gather_buffer.sv
// Gathers returned load words into a writeback vector, or drains a store vector word by word.
module lsu_wb_gather_buffer
  import lsu_wb_gather_buffer_pkg::*;
#(
  parameter int unsigned WORD_W = LSU_WORD_W,
  parameter int unsigned LANES  = LSU_LANES,
  parameter int unsigned TAG_W  = LSU_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ld_start,
  input  logic [TAG_W-1:0]        ld_tag,
  input  logic                    rd_valid,
  input  logic [WORD_W-1:0]       rd_data,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [LANES*WORD_W-1:0] wb_data,
  output logic [TAG_W-1:0]        wb_tag,
  input  logic                    st_start,
  input  logic [LANES*WORD_W-1:0] st_data,
  output logic                    mem_wr_valid,
  output logic [WORD_W-1:0]       mem_wr_data,
  output logic                    mem_wr_last,
  input  logic                    mem_wr_ready,
  output logic                    busy,
  output logic                    err
);

  localparam int unsigned VEC_W = LANES * WORD_W;
  localparam int unsigned CNT_W = $clog2(LANES + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(LANES - 1);

  lsu_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              err_q, err_d;
  logic              buf_load, buf_shift;
  logic [WORD_W-1:0] buf_top;
  logic [VEC_W-1:0]  buf_q;

  lsu_word_shift_reg #(
    .WORD_W (WORD_W),
    .LANES  (LANES)
  ) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (buf_load),
    .load_data_i (st_data),
    .shift_i     (buf_shift),
    .top_word_i  (buf_top),
    .q_o         (buf_q)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    err_d     = 1'b0;
    buf_load  = 1'b0;
    buf_shift = 1'b0;
    buf_top   = '0;
    unique case (state_q)
      ST_IDLE: begin
        // A load wins a simultaneous start; the dropped store is flagged.
        if (ld_start) begin
          cnt_d   = '0;
          tag_d   = ld_tag;
          state_d = ST_GATHER;
          err_d   = st_start;
        end else if (st_start) begin
          buf_load = 1'b1;
          cnt_d    = '0;
          state_d  = ST_DRAIN;
        end
        if (rd_valid) err_d = 1'b1;
      end
      ST_GATHER: begin
        if (rd_valid) begin
          buf_shift = 1'b1;
          buf_top   = rd_data;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = ST_DONE;
        end
        if (ld_start || st_start) err_d = 1'b1;
      end
      ST_DONE: begin
        if (wb_ready) state_d = ST_IDLE;
        if (ld_start || st_start || rd_valid) err_d = 1'b1;
      end
      ST_DRAIN: begin
        if (mem_wr_ready) begin
          buf_shift = 1'b1;
          cnt_d     = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_IDX) state_d = ST_IDLE;
        end
        if (ld_start || st_start || rd_valid) err_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

  assign busy         = (state_q != ST_IDLE);
  assign err          = err_q;
  assign wb_valid     = (state_q == ST_DONE);
  assign wb_data      = buf_q;
  assign wb_tag       = tag_q;
  assign mem_wr_valid = (state_q == ST_DRAIN);
  assign mem_wr_data  = buf_q[WORD_W-1:0];
  assign mem_wr_last  = (state_q == ST_DRAIN) && (cnt_q == LAST_IDX);

endmodule

// File: tb/tb_lsu_wb_gather_buffer.sv
// Directed bench for lsu_wb_gather_buffer with LANES=4, WORD_W=32.
module tb_lsu_wb_gather_buffer;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANES  = 4;
  localparam int unsigned TAG_W  = 7;
  localparam int unsigned VEC_W  = WORD_W * LANES;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              ld_start = 1'b0;
  logic [TAG_W-1:0]  ld_tag = '0;
  logic              rd_valid = 1'b0;
  logic [WORD_W-1:0] rd_data = '0;
  logic              wb_valid;
  logic              wb_ready = 1'b0;
  logic [VEC_W-1:0]  wb_data;
  logic [TAG_W-1:0]  wb_tag;
  logic              st_start = 1'b0;
  logic [VEC_W-1:0]  st_data = '0;
  logic              mem_wr_valid;
  logic [WORD_W-1:0] mem_wr_data;
  logic              mem_wr_last;
  logic              mem_wr_ready = 1'b0;
  logic              busy;
  logic              err;

  int checks = 0;
  int errors = 0;

  lsu_word_shift_reg_dummy_guard u_guard ();

  lsu_wb_gather_buffer #(
    .WORD_W (WORD_W),
    .LANES  (LANES),
    .TAG_W  (TAG_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ld_start     (ld_start),
    .ld_tag       (ld_tag),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .wb_valid     (wb_valid),
    .wb_ready     (wb_ready),
    .wb_data      (wb_data),
    .wb_tag       (wb_tag),
    .st_start     (st_start),
    .st_data      (st_data),
    .mem_wr_valid (mem_wr_valid),
    .mem_wr_data  (mem_wr_data),
    .mem_wr_last  (mem_wr_last),
    .mem_wr_ready (mem_wr_ready),
    .busy         (busy),
    .err          (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd_word(input logic [WORD_W-1:0] w);
    rd_valid = 1'b1;
    rd_data  = w;
    step();
    rd_valid = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_busy"},  VEC_W'(busy), '0);
    chk({tag, "_wbv"},   VEC_W'(wb_valid), '0);
    chk({tag, "_mwv"},   VEC_W'(mem_wr_valid), '0);
    chk({tag, "_mwl"},   VEC_W'(mem_wr_last), '0);
  endtask

  initial begin
    logic [WORD_W-1:0] st_words [4];
    logic [VEC_W-1:0]  hold;
    int unsigned       k;

    // Reset state
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk_idle_outputs("rst");
    chk("rst_err",  VEC_W'(err), '0);
    chk("rst_data", wb_data, '0);
    chk("rst_tag",  VEC_W'(wb_tag), '0);
    chk("rst_mwd",  VEC_W'(mem_wr_data), '0);
    #2 rst_n = 1'b1;
    step();

    // Back-to-back gather
    ld_start = 1'b1; ld_tag = 7'h2A;
    step();
    ld_start = 1'b0;
    chk("g1_busy", VEC_W'(busy), VEC_W'(1));
    chk("g1_tag",  VEC_W'(wb_tag), VEC_W'(7'h2A));
    rd_word(32'h11);
    rd_word(32'h22);
    rd_word(32'h33);
    chk("g1_wbv_early", VEC_W'(wb_valid), '0);
    rd_word(32'h44);
    chk("g1_wbv",  VEC_W'(wb_valid), VEC_W'(1));
    chk("g1_data", wb_data, 128'h00000044_00000033_00000022_00000011);
    chk("g1_tag2", VEC_W'(wb_tag), VEC_W'(7'h2A));
    chk("g1_err",  VEC_W'(err), '0);
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk_idle_outputs("g1_end");

    // Gather with gaps and a stalled consumer
    ld_start = 1'b1; ld_tag = 7'h15;
    step();
    ld_start = 1'b0;
    rd_word(32'h101);
    step();
    rd_word(32'h202);
    step();
    step();
    rd_word(32'h303);
    step();
    rd_word(32'h404);
    for (int i = 0; i < 5; i++) begin
      chk("g2_wbv",  VEC_W'(wb_valid), VEC_W'(1));
      chk("g2_data", wb_data, 128'h00000404_00000303_00000202_00000101);
      chk("g2_tag",  VEC_W'(wb_tag), VEC_W'(7'h15));
      step();
    end
    chk("g2_wbv_stall", VEC_W'(wb_valid), VEC_W'(1));
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk_idle_outputs("g2_end");

    // Store drain with toggling ready
    st_words[0] = 32'hA; st_words[1] = 32'hB; st_words[2] = 32'hC; st_words[3] = 32'hD;
    st_start = 1'b1;
    st_data  = {st_words[3], st_words[2], st_words[1], st_words[0]};
    step();
    st_start = 1'b0;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      mem_wr_ready = cyc[0];
      #1;
      chk("st_valid", VEC_W'(mem_wr_valid), VEC_W'(1));
      chk("st_data",  VEC_W'(mem_wr_data), VEC_W'(st_words[k]));
      chk("st_last",  VEC_W'(mem_wr_last), VEC_W'(k == 3));
      chk("st_wbv",   VEC_W'(wb_valid), '0);
      step();
      if (mem_wr_ready) k++;
    end
    mem_wr_ready = 1'b0;
    chk("st_count", VEC_W'(k), VEC_W'(4));
    chk_idle_outputs("st_end");

    // Simultaneous load and store start
    ld_start = 1'b1; ld_tag = 7'h01;
    st_start = 1'b1; st_data = '1;
    step();
    ld_start = 1'b0; st_start = 1'b0;
    chk("both_busy", VEC_W'(busy), VEC_W'(1));
    chk("both_mwv",  VEC_W'(mem_wr_valid), '0);
    chk("both_err",  VEC_W'(err), VEC_W'(1));
    step();
    chk("both_err_clr", VEC_W'(err), '0);
    rd_word(32'h5);
    rd_word(32'h6);
    rd_word(32'h7);
    rd_word(32'h8);
    chk("both_wbv",  VEC_W'(wb_valid), VEC_W'(1));
    chk("both_data", wb_data, 128'h00000008_00000007_00000006_00000005);
    chk("both_tag",  VEC_W'(wb_tag), VEC_W'(7'h01));
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;

    // Stray read return in IDLE
    rd_valid = 1'b1; rd_data = 32'hDEAD;
    step();
    rd_valid = 1'b0;
    chk("rdidle_err",  VEC_W'(err), VEC_W'(1));
    chk("rdidle_busy", VEC_W'(busy), '0);
    chk("rdidle_data", wb_data, 128'h00000008_00000007_00000006_00000005);

    // Load start during drain
    st_start = 1'b1; st_data = 128'h00000004_00000003_00000002_00000001;
    step();
    st_start = 1'b0;
    chk("ldrain_err0", VEC_W'(err), '0);
    chk("ldrain_mwd0", VEC_W'(mem_wr_data), VEC_W'(32'h1));
    ld_start = 1'b1; ld_tag = 7'h7F;
    step();
    ld_start = 1'b0;
    hold = wb_data;
    chk("ldrain_err",  VEC_W'(err), VEC_W'(1));
    chk("ldrain_busy", VEC_W'(mem_wr_valid), VEC_W'(1));
    chk("ldrain_data", hold, 128'h00000004_00000003_00000002_00000001);
    chk("ldrain_tag",  VEC_W'(wb_tag), VEC_W'(7'h01));
    mem_wr_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("ldrain_word", VEC_W'(mem_wr_data), VEC_W'(i));
      chk("ldrain_last", VEC_W'(mem_wr_last), VEC_W'(i == 4));
      step();
    end
    mem_wr_ready = 1'b0;
    chk_idle_outputs("ldrain_end");

    // Reset in the middle of a gather
    ld_start = 1'b1; ld_tag = 7'h33;
    step();
    ld_start = 1'b0;
    rd_word(32'h11);
    rd_word(32'h22);
    #2 rst_n = 1'b0;
    #1;
    chk_idle_outputs("mrst");
    chk("mrst_data", wb_data, '0);
    chk("mrst_tag",  VEC_W'(wb_tag), '0);
    #3 rst_n = 1'b1;
    step();
    step();
    chk_idle_outputs("mrst_rel");
    ld_start = 1'b1; ld_tag = 7'h44;
    step();
    ld_start = 1'b0;
    rd_word(32'hA1);
    rd_word(32'hA2);
    rd_word(32'hA3);
    chk("mrst_wbv_early", VEC_W'(wb_valid), '0);
    rd_word(32'hA4);
    chk("mrst_wbv",  VEC_W'(wb_valid), VEC_W'(1));
    chk("mrst_data2", wb_data, 128'h000000A4_000000A3_000000A2_000000A1);
    chk("mrst_tag2", VEC_W'(wb_tag), VEC_W'(7'h44));
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("mrst_end_busy", VEC_W'(busy), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

module lsu_word_shift_reg_dummy_guard;
endmodule
